// File: rtl/contador_pkg.sv
// Shared definitions for the countdown slice: controller state encoding,
// countdown width and the 7-segment glyph table used by the display path.
package contador_pkg;

  localparam int unsigned CNT_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    PAUSE,
    DONE
  } ctrl_state_t;

  // Segment patterns {g,f,e,d,c,b,a}, active high, index = decimal digit.
  localparam logic [9:0][6:0] SEG7_TABLE = '{
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector for an already synchronized level input.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset (clears history)
//   d     - level input
//   pulse - high for one cycle when d is 1 and was 0 on the previous cycle
module detector_flanco (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= d;
  end

  assign pulse = d & ~prev;

endmodule

// File: rtl/contador_ctrl.sv
// Sequencing controller for the 6-bit countdown datapath and its two-digit
// display: turns start/pause buttons into load, enable and blank controls,
// generates the count tick with an internal prescaler and reports completion.
// Optional build macro: AUTO_RELOAD_EN (reaching zero reloads load_val and
// restarts instead of entering DONE, unless load_val is 0).
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   btn_start     - start/restart level, acted on at rising edge
//   btn_pause     - pause/resume level, acted on at rising edge
//   load_val      - start value from switches, sampled in LOAD
//   cnt_zero      - datapath count == 0
//   cnt_load      - one-cycle load pulse, cnt_load_val carries the value
//   cnt_en        - one-cycle decrement pulse
//   busy / done   - LOAD, RUN, PAUSE / DONE indications
//   blank         - display blank, blinks in DONE
module contador_ctrl
  import contador_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 50_000_000,
  parameter int unsigned BLINK_DIV = 25_000_000,
  parameter int unsigned WIDTH     = CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_pause,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cnt_zero,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic             blank
);

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  ctrl_state_t   state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [BW-1:0] blink_q;
  logic          blank_q;
  logic          start_e, pause_e;
  logic          tick;

  detector_flanco u_det_start (
    .clk   (clk),
    .rst   (rst),
    .d     (btn_start),
    .pulse (start_e)
  );

  detector_flanco u_det_pause (
    .clk   (clk),
    .rst   (rst),
    .d     (btn_pause),
    .pulse (pause_e)
  );

  // Start has priority over every other event in every state.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    tick    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_e) state_d = LOAD;
      end
      LOAD: begin
        pre_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (start_e) begin
          state_d = LOAD;
        end else if (cnt_zero) begin
`ifdef AUTO_RELOAD_EN
          // A zero reload would spin LOAD/RUN forever, so it stops in DONE.
          state_d = (load_val == '0) ? DONE : LOAD;
`else
          state_d = DONE;
`endif
        end else if (pause_e) begin
          state_d = PAUSE;
        end else if (pre_q == PRE_MAX) begin
          pre_d = '0;
          tick  = 1'b1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      PAUSE: begin
        if (start_e)      state_d = LOAD;
        else if (pause_e) state_d = RUN;
      end
      DONE: begin
        if (start_e) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      blink_q <= '0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      // Blink only while staying in DONE; any exit (or entry) starts clean.
      if (state_q == DONE && state_d == DONE) begin
        if (blink_q == BLINK_MAX) begin
          blink_q <= '0;
          blank_q <= ~blank_q;
        end else begin
          blink_q <= blink_q + 1'b1;
        end
      end else begin
        blink_q <= '0;
        blank_q <= 1'b0;
      end
    end
  end

  // Outputs are gated by rst so a reset cycle never emits a pulse.
  assign cnt_load     = ~rst & (state_q == LOAD);
  assign cnt_load_val = cnt_load ? load_val : '0;
  assign cnt_en       = ~rst & tick;
  assign busy         = ~rst & (state_q == LOAD || state_q == RUN || state_q == PAUSE);
  assign done         = ~rst & (state_q == DONE);
  assign blank        = ~rst & (state_q == DONE) & blank_q;

endmodule
